pressure_abnormality_monitor: RTL and testbench

Multi-channel, parametrised successor to the single-channel combinational pressure abnormality detector. It compares each channel's pressure sample against runtime-programmable low/high limits. An alarm is raised only after a configurable number of consecutive abnormal samples, and is released only after the same number of consecutive samples inside a hysteresis band. Sits between the sensor sampling front end and the alarm/display logic; provides per-channel live alarms, sticky flags and a saturating event counter.

---
 rtl/pressure_pkg.sv | 38 +++
 rtl/pressure_channel_fsm.sv | 104 ++++++++++
 rtl/pressure_abnormality_monitor.sv | 89 ++++++++
 tb/tb_pressure_abnormality_monitor.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pressure_pkg.sv
// Shared types and the sample classifier for the pressure abnormality monitor.
// Channel samples are zero-extended to MAX_W bits before classification.
package pressure_pkg;

  localparam int DEF_DATA_W  = 6;
  localparam int DEF_PERSIST = 3;
  localparam int MAX_W       = 16;

  typedef enum logic [1:0] {
    NORMAL,
    PENDING,
    ALARM,
    RECOVERING
  } chan_state_e;

  typedef struct packed {
    logic abnormal;
    logic recovered;
  } class_t;

  function automatic class_t classify(input logic [MAX_W-1:0] value,
                                      input logic [MAX_W-1:0] low,
                                      input logic [MAX_W-1:0] high,
                                      input logic [MAX_W-1:0] hyst,
                                      input logic             cfg_err);
    logic [MAX_W:0] lo_rec;
    logic [MAX_W:0] hi_rec;
    class_t         r;
    lo_rec = {1'b0, low} + {1'b0, hyst};
    hi_rec = {1'b0, high} - {1'b0, hyst};
    r.abnormal  = cfg_err || (value < low) || (value > high);
    // The borrow bit of hi_rec flags an empty recovery band.
    r.recovered = !cfg_err && !hi_rec[MAX_W] &&
                  ({1'b0, value} >= lo_rec) && ({1'b0, value} <= hi_rec);
    return r;
  endfunction

endpackage

// File: rtl/pressure_channel_fsm.sv
// One channel: classify the sample, run the persistence FSM, and flag alarm entry.
// alarm_event is combinational and marks the edge on which ALARM is entered.
module pressure_channel_fsm
  import pressure_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PERSIST = DEF_PERSIST
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] low_thresh,
  input  logic [DATA_W-1:0] high_thresh,
  input  logic [DATA_W-1:0] hyst,
  input  logic              cfg_err,
  output logic              alarm,
  output logic              alarm_event
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             alarm_q, alarm_d;
  logic             event_d;
  class_t           cls;

  always_comb begin
    cls     = classify(MAX_W'(value), MAX_W'(low_thresh), MAX_W'(high_thresh),
                       MAX_W'(hyst), cfg_err);
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    event_d = 1'b0;
    if (sample_valid) begin
      case (state_q)
        NORMAL: begin
          if (cls.abnormal) begin
            cnt_d = CNT_W'(1);
            if (PERSIST == 1) begin
              state_d = ALARM;
              event_d = 1'b1;
            end else begin
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (cls.abnormal) begin
            cnt_d = cnt_inc[CNT_W-1:0];
            if (cnt_inc == (CNT_W+1)'(PERSIST)) begin
              state_d = ALARM;
              event_d = 1'b1;
            end
          end else begin
            state_d = NORMAL;
            cnt_d   = '0;
          end
        end
        ALARM: begin
          if (cls.recovered) begin
            cnt_d   = CNT_W'(1);
            state_d = (PERSIST == 1) ? NORMAL : RECOVERING;
          end else begin
            cnt_d = '0;
          end
        end
        RECOVERING: begin
          // Any sample that is not fully recovered restarts the release count.
          if (cls.recovered) begin
            cnt_d = cnt_inc[CNT_W-1:0];
            if (cnt_inc == (CNT_W+1)'(PERSIST)) state_d = NORMAL;
          end else begin
            state_d = ALARM;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
    alarm_d = (state_d == ALARM) || (state_d == RECOVERING);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm       = alarm_q;
  assign alarm_event = event_d;

endmodule

// File: rtl/pressure_abnormality_monitor.sv
// Multi-channel pressure monitor: per-channel persistence FSMs plus shared
// sticky flags, threshold sanity check and a saturating alarm-event counter.
module pressure_abnormality_monitor
  import pressure_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = 4,
  parameter int PERSIST  = DEF_PERSIST,
  parameter int EVT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       sampleValid,
  input  logic [CHANNELS*DATA_W-1:0] pressureData,
  input  logic [DATA_W-1:0]          lowThresh,
  input  logic [DATA_W-1:0]          highThresh,
  input  logic [DATA_W-1:0]          hyst,
  input  logic [CHANNELS-1:0]        clearSticky,
  input  logic                       clearCount,
  output logic [CHANNELS-1:0]        presureAlarm,
  output logic [CHANNELS-1:0]        stickyAlarm,
  output logic                       anyAlarm,
  output logic                       configError,
  output logic [EVT_W-1:0]           eventCount
);

  localparam int SUM_W = EVT_W + $clog2(CHANNELS + 1);

  logic [CHANNELS-1:0] chan_event;
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic                config_error_q, config_error_d;
  logic [EVT_W-1:0]    event_count_q, event_count_d;
  logic [SUM_W-1:0]    evt_sum;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      pressure_channel_fsm #(
        .DATA_W (DATA_W),
        .PERSIST(PERSIST)
      ) u_chan (
        .clk         (clk),
        .rstN        (rstN),
        .sample_valid(sampleValid),
        .value       (pressureData[gi*DATA_W +: DATA_W]),
        .low_thresh  (lowThresh),
        .high_thresh (highThresh),
        .hyst        (hyst),
        .cfg_err     (config_error_q),
        .alarm       (presureAlarm[gi]),
        .alarm_event (chan_event[gi])
      );
    end
  endgenerate

  always_comb begin
    config_error_d = lowThresh > highThresh;
    // A new event outranks a same-cycle clear.
    sticky_d       = chan_event | (sticky_q & ~clearSticky);
    evt_sum        = SUM_W'(event_count_q);
    for (int i = 0; i < CHANNELS; i++) begin
      evt_sum = evt_sum + SUM_W'(chan_event[i]);
    end
    if (clearCount) begin
      event_count_d = '0;
    end else if (evt_sum > SUM_W'({EVT_W{1'b1}})) begin
      event_count_d = '1;
    end else begin
      event_count_d = evt_sum[EVT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sticky_q       <= '0;
      config_error_q <= 1'b0;
      event_count_q  <= '0;
    end else begin
      sticky_q       <= sticky_d;
      config_error_q <= config_error_d;
      event_count_q  <= event_count_d;
    end
  end

  assign stickyAlarm = sticky_q;
  assign configError = config_error_q;
  assign eventCount  = event_count_q;
  assign anyAlarm    = |presureAlarm;

endmodule

// File: tb/tb_pressure_abnormality_monitor.sv
// Vector-table bench for pressure_abnormality_monitor (4 channels, PERSIST=3, EVT_W=2).
module tb_pressure_abnormality_monitor;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        sampleValid = 1'b0;
  logic [23:0] pressureData = '0;
  logic [5:0]  lowThresh = 6'd8;
  logic [5:0]  highThresh = 6'd48;
  logic [5:0]  hyst = 6'd2;
  logic [3:0]  clearSticky = '0;
  logic        clearCount = 1'b0;
  logic [3:0]  presureAlarm;
  logic [3:0]  stickyAlarm;
  logic        anyAlarm;
  logic        configError;
  logic [1:0]  eventCount;

  pressure_abnormality_monitor #(
    .DATA_W(6), .CHANNELS(4), .PERSIST(3), .EVT_W(2)
  ) dut (
    .clk(clk), .rstN(rstN), .sampleValid(sampleValid), .pressureData(pressureData),
    .lowThresh(lowThresh), .highThresh(highThresh), .hyst(hyst),
    .clearSticky(clearSticky), .clearCount(clearCount),
    .presureAlarm(presureAlarm), .stickyAlarm(stickyAlarm), .anyAlarm(anyAlarm),
    .configError(configError), .eventCount(eventCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [23:0] data;
    logic [5:0]  lo, hi, hy;
    logic [3:0]  cs;
    logic        cc;
    logic [3:0]  ea, es;
    logic        ecfg;
    logic [1:0]  ec;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_no = 0;
  logic [5:0] lo_v = 6'd8, hi_v = 6'd48, hy_v = 6'd2;
  logic       ecfg_v = 1'b0;

  function automatic vec_t mk(logic v, int d0, int d1, int d2, int d3,
                              logic [3:0] cs, logic cc,
                              logic [3:0] ea, logic [3:0] es, logic [1:0] ec);
    vec_t r;
    r.valid = v;
    r.data  = {6'(d3), 6'(d2), 6'(d1), 6'(d0)};
    r.lo = lo_v; r.hi = hi_v; r.hy = hy_v;
    r.cs = cs; r.cc = cc; r.ea = ea; r.es = es; r.ec = ec; r.ecfg = ecfg_v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, vec_no, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    sampleValid  = v.valid;
    pressureData = v.data;
    lowThresh    = v.lo;
    highThresh   = v.hi;
    hyst         = v.hy;
    clearSticky  = v.cs;
    clearCount   = v.cc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("alarm",  32'(presureAlarm), 32'(e.ea));
    chk("sticky", 32'(stickyAlarm),  32'(e.es));
    chk("any",    32'(anyAlarm),     32'(|e.ea));
    chk("cfg",    32'(configError),  32'(e.ecfg));
    chk("count",  32'(eventCount),   32'(e.ec));
    $display("vec %0d: valid=%0b data=%h alarm=%h sticky=%h cnt=%0d cfg=%0b",
             vec_no, v.valid, v.data, presureAlarm, stickyAlarm, eventCount, configError);
    vec_no++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alarm"},  32'(presureAlarm), 32'd0);
    chk({tag, "_sticky"}, 32'(stickyAlarm),  32'd0);
    chk({tag, "_any"},    32'(anyAlarm),     32'd0);
    chk({tag, "_cfg"},    32'(configError),  32'd0);
    chk({tag, "_count"},  32'(eventCount),   32'd0);
  endtask

  initial begin
    // Boundaries on ch0, then a 49/7/49 run that does alarm, then release.
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1,  7, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1, 49, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1, 48, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1,  8, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1, 49, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1,  7, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1, 49, 20, 20, 20, 4'h0, 0, 4'h1, 4'h1, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h1, 4'h1, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h1, 4'h1, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h1, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h1, 1, 4'h0, 4'h0, 2'd0));
    // Persistence on ch1, then the hysteresis sequence 20,9,20,20,20.
    tbl.push_back(mk(1, 20,  1, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1, 20,  1, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    tbl.push_back(mk(1, 20,  1, 20, 20, 4'h0, 0, 4'h2, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h2, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20,  9, 20, 20, 4'h0, 0, 4'h2, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h2, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h2, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    // Broken run 1,1,20,1 on ch1.
    tbl.push_back(mk(1, 20,  1, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20,  1, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20,  1, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    // ch2 run with sampleValid gaps; data on invalid cycles must be ignored.
    tbl.push_back(mk(1, 20, 20,  1, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(0, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20,  1, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(0, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h2, 2'd1));
    tbl.push_back(mk(1, 20, 20,  1, 20, 4'h0, 0, 4'h4, 4'h6, 2'd2));
    tbl.push_back(mk(0, 20, 20, 20, 20, 4'h0, 0, 4'h4, 4'h6, 2'd2));

    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Reset in the middle of a ch0 PENDING run discards history.
    run_vec(mk(1, 1, 20, 20, 20, 4'h0, 0, 4'h4, 4'h6, 2'd2));
    @(negedge clk);
    sampleValid = 1'b0;
    rstN = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rstN = 1'b1;
    run_vec(mk(1, 1, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    run_vec(mk(1, 1, 20, 20, 20, 4'h0, 0, 4'h0, 4'h0, 2'd0));
    run_vec(mk(1, 1, 20, 20, 20, 4'h0, 0, 4'h1, 4'h1, 2'd1));

    // Release ch0, then all four channels alarm together: 1+4 saturates at 3.
    run_vec(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h1, 4'h1, 2'd1));
    run_vec(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h1, 4'h1, 2'd1));
    run_vec(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'h1, 2'd1));
    run_vec(mk(1,  1,  1,  1,  1, 4'h1, 0, 4'h0, 4'h0, 2'd1));
    run_vec(mk(1,  1,  1,  1,  1, 4'h0, 0, 4'h0, 4'h0, 2'd1));
    run_vec(mk(1,  1,  1,  1,  1, 4'h4, 0, 4'hF, 4'hF, 2'd3));
    run_vec(mk(1,  1,  1,  1,  1, 4'h0, 1, 4'hF, 4'hF, 2'd0));
    run_vec(mk(1,  1,  1,  1,  1, 4'h0, 0, 4'hF, 4'hF, 2'd0));

    // Recover everything, then inverted thresholds force abnormal samples.
    run_vec(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'hF, 4'hF, 2'd0));
    run_vec(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'hF, 4'hF, 2'd0));
    run_vec(mk(1, 20, 20, 20, 20, 4'h0, 0, 4'h0, 4'hF, 2'd0));
    lo_v = 6'd40; hi_v = 6'd10; ecfg_v = 1'b1;
    run_vec(mk(0, 25, 25, 25, 25, 4'h0, 0, 4'h0, 4'hF, 2'd0));
    run_vec(mk(1, 25, 25, 25, 25, 4'h0, 0, 4'h0, 4'hF, 2'd0));
    run_vec(mk(1, 25, 25, 25, 25, 4'h0, 0, 4'h0, 4'hF, 2'd0));
    run_vec(mk(1, 25, 25, 25, 25, 4'h0, 0, 4'hF, 4'hF, 2'd3));
    lo_v = 6'd8; hi_v = 6'd48; ecfg_v = 1'b0;
    run_vec(mk(0, 25, 25, 25, 25, 4'h0, 0, 4'hF, 4'hF, 2'd3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
